alu_rr_scheduler: RTL

Shares one combinational 32-bit ALU (add/sub with zero flag; all other opcodes give result 0) among NUM_REQ requesters. Round-robin arbitration over valid/ready request channels. The block registers the winning operands into the ALU, captures result and zero one cycle later, and returns them on a single tagged response channel. It sits between the requesting engines and the shared ALU instance, and owns that ALU's input ports.

---
 rtl/alu_rr_scheduler_if.sv | 38 +++
 rtl/alu_rr_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler_if
// Request/response bundle between the requesting engines and alu_rr_scheduler.
//   req_valid/req_ready : per-requester handshake (one bit per requester)
//   req_a/req_b/req_op  : packed per-requester operands, requester i at
//                         [DATA_W*i +: DATA_W] / [OP_W*i +: OP_W]
//   rsp_*               : single tagged response channel
// master = requester/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic                      rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one combinational ALU among NUM_REQ requesters. A round-robin
// arbiter picks a requester, its operands are registered onto the ALU
// inputs, the ALU result is captured one cycle later and returned on a
// tagged response channel.
// Ports:
//   clk, rst        : single clock, synchronous active-high reset
//   bus (slave)     : request channels in, response channel out
//   alu_a/b/op      : registered ALU inputs (hold value while idle)
//   alu_result/zero : ALU outputs
//   busy            : high whenever an operation is in flight
//   op_count        : completed responses, wraps at 16 bits
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_rr_scheduler_if.slave   bus,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    output logic                busy,
    output logic [15:0]         op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q,      state_d;
    logic [ID_W-1:0]     rr_ptr_q,     rr_ptr_d;
    logic [ID_W-1:0]     id_q,         id_d;
    logic [DATA_W-1:0]   alu_a_q,      alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,      alu_b_d;
    logic [OP_W-1:0]     alu_op_q,     alu_op_d;
    logic                rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q,     rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_zero_q,   rsp_zero_d;
    logic                rsp_err_q,    rsp_err_d;
    logic [15:0]         op_count_q,   op_count_d;

    logic                arb_en;
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;

    // Unpacked views of the packed request buses.
    logic [DATA_W-1:0]   a_arr  [NUM_REQ];
    logic [DATA_W-1:0]   b_arr  [NUM_REQ];
    logic [OP_W-1:0]     op_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]  = bus.req_a[DATA_W*i +: DATA_W];
        assign b_arr[i]  = bus.req_b[DATA_W*i +: DATA_W];
        assign op_arr[i] = bus.req_op[OP_W*i +: OP_W];
    end

    // Arbitration may only happen when the ALU input registers are free:
    // idle, or the current response is leaving this very cycle.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        arb_en      = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
        grant_found = 1'b0;
        grant_idx   = '0;
        // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
        grant_found = grant_found && arb_en;
    end

    assign bus.req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;

        case (state_q)
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_id_d     = id_q;
                rsp_err_d    = (alu_op_q != OP_W'(0)) && (alu_op_q != OP_W'(1));
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    op_count_d  = op_count_q + 16'd1;
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        // A grant (from IDLE or the closing RESP cycle) loads the ALU inputs
        // and overrides the state chosen above.
        if (grant_found) begin
            alu_a_d  = a_arr[grant_idx];
            alu_b_d  = b_arr[grant_idx];
            alu_op_d = op_arr[grant_idx];
            id_d     = grant_idx;
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            state_d  = EXEC;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state_q != IDLE);
    assign op_count       = op_count_q;

endmodule
